// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (registered read data) into a
// valid/ready stream with packet framing (m_last every PKT_LEN beats).
// A 3-entry skid buffer absorbs the one-cycle FIFO read latency, so reads
// never depend combinationally on m_ready.
// Optional flush support is built when FIFO_RD_FLUSH_EN is defined.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef FIFO_RD_FLUSH_EN
    ,
    input  logic                  flush,
    output logic                  flush_busy
`endif
);

`ifdef FIFO_RD_FLUSH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t                state;
    state_t                state_next;
    logic [1:0]            occ;
    logic                  infl;
    logic [DATA_WIDTH-1:0] entries [3];
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic                  push;
    logic                  pop;
    logic                  room;
    logic                  in_flush;
    logic                  flush_clear;
    logic [1:0]            wr_idx;

`ifdef FIFO_RD_FLUSH_EN
    assign in_flush    = (state == FLUSH);
    assign flush_clear = flush && !in_flush;
    assign flush_busy  = in_flush;
`else
    assign in_flush    = 1'b0;
    assign flush_clear = 1'b0;
`endif

    // A read is only issued when its data is guaranteed a free buffer entry
    assign room    = ({1'b0, occ} + {2'b00, infl}) <= 3'd2;
    assign m_valid = (occ != 2'd0);
    assign m_data  = entries[0];
    assign m_last  = m_valid && (beat_cnt == CNT_WIDTH'(PKT_LEN - 1));
    assign pop     = m_valid && m_ready;
    // Data returned during a flush is dropped rather than buffered
    assign push    = infl && !in_flush;
    assign wr_idx  = pop ? (occ - 2'd1) : occ;

    // Next-state and read strobe decode from registered state
    always_comb begin
        state_next   = state;
        fifo_read_en = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                fifo_read_en = !fifo_empty && room;
                if (!enable) state_next = IDLE;
            end
`ifdef FIFO_RD_FLUSH_EN
            FLUSH: begin
                fifo_read_en = !fifo_empty;
                if (fifo_empty && !infl) state_next = enable ? RUN : IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
`ifdef FIFO_RD_FLUSH_EN
        if (flush_clear) state_next = FLUSH;
`endif
    end

    // Control registers: state, in-flight flag, occupancy, beat counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            infl     <= 1'b0;
            occ      <= 2'd0;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            infl  <= fifo_read_en;
            if (flush_clear) begin
                occ      <= 2'd0;
                beat_cnt <= '0;
            end else begin
                case ({push, pop})
                    2'b10:   occ <= occ + 2'd1;
                    2'b01:   occ <= occ - 2'd1;
                    default: occ <= occ;
                endcase
                if (pop) beat_cnt <= m_last ? '0 : beat_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Buffer storage: shift toward the head on pop, write captured data at tail
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) entries[i] <= '0;
        end else begin
            if (pop) begin
                entries[0] <= entries[1];
                entries[1] <= entries[2];
            end
            if (push && (wr_idx != 2'd3)) entries[wr_idx] <= fifo_data;
        end
    end

`ifndef SYNTHESIS
    // Read gating must keep every capture within the 3 buffer entries
    assert property (@(posedge clk) disable iff (!reset_n) push |-> (occ != 2'd3))
        else $error("fifo_stream_reader: capture into full buffer");
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-based FIFO model feeds the
// DUT, every word handed over is expected on the stream in order, and a
// monitor checks data, framing, stall stability and buffer bound.
module tb_fifo_stream_reader;
    localparam int DATA_WIDTH = 16;
    localparam int PKT_LEN    = 4;
    localparam int CNT_WIDTH  = 2;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  enable = 1'b0;
    logic                  fifo_read_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
`ifdef FIFO_RD_FLUSH_EN
    logic                  flush = 1'b0;
    logic                  flush_busy;
`endif
    logic                  wr_en = 1'b0;
    logic [DATA_WIDTH-1:0] wr_data = '0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH(DATA_WIDTH), .PKT_LEN(PKT_LEN), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .fifo_read_en(fifo_read_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef FIFO_RD_FLUSH_EN
        , .flush(flush), .flush_busy(flush_busy)
`endif
    );

    logic [DATA_WIDTH-1:0] fq[$];
    logic [DATA_WIDTH-1:0] exp_q[$];
    int    handed = 0;
    bit    discard = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    xfer = 0;
    int    dropped = 0;
    int    sb_beat = 0;
    int    clr_req = 0;
    int    clr_seen = 0;
    string dq_name[$];
    int    dq_act[$];
    int    dq_exp[$];

    // Synchronous FIFO model: registered read data, accurate empty flag
    initial begin
        logic [DATA_WIDTH-1:0] w;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        forever begin
            @(posedge clk);
            if (fifo_read_en && fq.size() > 0) begin
                w = fq.pop_front();
                fifo_data <= w;
                if (!discard) begin
                    exp_q.push_back(w);
                    handed++;
                end
            end
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Monitor: directed checks plus stream scoreboard
    initial begin
        bit prev_stall = 1'b0;
        logic [DATA_WIDTH-1:0] prev_data = '0;
        logic [DATA_WIDTH-1:0] e;
        bit exp_last;
        int held;
        string n;
        int a;
        int x;
        forever begin
            @(negedge clk);
            while (dq_name.size() > 0) begin
                n = dq_name.pop_front();
                a = dq_act.pop_front();
                x = dq_exp.pop_front();
                checks++;
                if (a != x) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", n, a, x);
                end
            end
            if (clr_seen != clr_req) begin
                clr_seen = clr_req;
                exp_q.delete();
                sb_beat = 0;
                dropped = handed - xfer;
                prev_stall = 1'b0;
            end
            if (reset_n) begin
                checks++;
                if (fifo_read_en && fifo_empty) begin
                    errors++;
                    $display("FAIL read_when_empty: got read_en=1 required 0");
                end
                held = handed - xfer - dropped;
                checks++;
                if (held > 3) begin
                    errors++;
                    $display("FAIL held_bound: got %0d required <=3", held);
                end
                if (prev_stall && !discard) begin
                    checks++;
                    if (!m_valid || m_data != prev_data) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b d=%h required v=1 d=%h", m_valid, m_data, prev_data);
                    end
                end
                if (m_valid && m_ready) begin
                    checks++;
                    exp_last = ((sb_beat % PKT_LEN) == PKT_LEN - 1);
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: got %h required none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_data != e || m_last != exp_last) begin
                            errors++;
                            $display("FAIL beat%0d: got %h last=%0b required %h last=%0b",
                                     sb_beat, m_data, m_last, e, exp_last);
                        end
                    end
                    sb_beat++;
                    xfer++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dchk(input string n, input int a, input int x);
        dq_name.push_back(n);
        dq_act.push_back(a);
        dq_exp.push_back(x);
    endtask

    task automatic write_word(input logic [DATA_WIDTH-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step();
        wr_en   = 1'b0;
    endtask

    // Stimulus
    initial begin
        int rd_i, v_i, last_i, n, x0, rc, cnt;
        bit hit;

        // Reset values
        step(); step();
        dchk("rst_read_en", int'(fifo_read_en), 0);
        dchk("rst_valid", int'(m_valid), 0);
        dchk("rst_data", int'(m_data), 0);
        dchk("rst_last", int'(m_last), 0);
        reset_n = 1'b1;
        step();

        // Burst of 8 words at full rate
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) write_word(DATA_WIDTH'(i));
        step();
        enable = 1'b1;
        rd_i = -1; v_i = -1; last_i = -1; n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (fifo_read_en && rd_i < 0) rd_i = i;
            if (m_valid && v_i < 0) v_i = i;
            if (m_valid && m_ready) begin
                n++;
                last_i = i;
            end
        end
        dchk("burst_latency", v_i - rd_i, 2);
        dchk("burst_span", last_i - v_i, 7);
        dchk("burst_count", n, 8);

        // Same words with m_ready pattern 1,0,0,1
        enable = 1'b0;
        for (int i = 1; i <= 8; i++) write_word(DATA_WIDTH'(i));
        step();
        x0 = xfer;
        enable = 1'b1;
        for (int i = 0; i < 48; i++) begin
            m_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        m_ready = 1'b1;
        step();
        dchk("toggle_count", xfer - x0, 8);
        dchk("toggle_fifo_left", fq.size(), 0);

        // Drop enable in the cycle a read issues
        enable = 1'b0;
        step();
        write_word(16'h00AA);
        write_word(16'h00BB);
        step();
        x0 = xfer;
        enable = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            hit = fifo_read_en;
        end
        dchk("en_drop_read_seen", int'(hit), 1);
        enable = 1'b0;
        rc = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            rc += int'(fifo_read_en);
        end
        dchk("en_drop_no_reads", rc, 0);
        dchk("en_drop_fifo_left", fq.size(), 1);
        dchk("en_drop_delivered", xfer - x0, 1);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Empty FIFO: no reads, no beats; then a single word
        rc = 0; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            rc += int'(fifo_read_en);
            cnt += int'(m_valid);
        end
        dchk("empty_reads", rc, 0);
        dchk("empty_valid", cnt, 0);
        x0 = xfer;
        write_word(16'h1234);
        rc = 0;
        for (int i = 0; i < 10; i++) begin
            if (fifo_read_en) rc++;
            step();
        end
        dchk("single_reads", rc, 1);
        dchk("single_beats", xfer - x0, 1);

        // Reset mid-stream with two buffered beats and one read in flight
        enable = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) write_word(DATA_WIDTH'(16'h0100 + i));
        step();
        enable = 1'b1;
        rc = 0;
        for (int i = 0; i < 20 && rc < 3; i++) begin
            step();
            if (fifo_read_en) rc++;
        end
        dchk("midrst_reads", rc, 3);
        step();
        dchk("midrst_valid_before", int'(m_valid), 1);
        reset_n = 1'b0;
        clr_req++;
        #1;
        dchk("midrst_read_en", int'(fifo_read_en), 0);
        dchk("midrst_valid", int'(m_valid), 0);
        dchk("midrst_data", int'(m_data), 0);
        dchk("midrst_last", int'(m_last), 0);
        step();
        reset_n = 1'b1;
        m_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = m_valid;
        end
        dchk("restart_valid_seen", int'(hit), 1);
        dchk("restart_first_data", int'(m_data), 16'h0104);
        dchk("restart_first_last", int'(m_last), 0);
        for (int i = 0; i < 10; i++) step();

`ifdef FIFO_RD_FLUSH_EN
        // Flush with two beats buffered and six words left in the FIFO
        enable = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) write_word(DATA_WIDTH'(16'h0200 + i));
        step();
        enable = 1'b1;
        rc = 0;
        for (int i = 0; i < 20 && rc < 2; i++) begin
            step();
            if (fifo_read_en) rc++;
        end
        enable = 1'b0;
        step(); step();
        dchk("flush_pre_fifo", fq.size(), 6);
        flush = 1'b1;
        discard = 1'b1;
        clr_req++;
        step();
        flush = 1'b0;
        dchk("flush_valid", int'(m_valid), 0);
        dchk("flush_busy_on", int'(flush_busy), 1);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            hit = !flush_busy;
        end
        dchk("flush_exit", int'(hit), 1);
        dchk("flush_fifo_drained", fq.size(), 0);
        dchk("flush_valid_after", int'(m_valid), 0);
        step();
        discard = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        x0 = xfer;
        for (int i = 1; i <= 4; i++) write_word(DATA_WIDTH'(16'h0300 + i));
        for (int i = 0; i < 12; i++) step();
        dchk("flush_next_pkt", xfer - x0, 4);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            wr_en   = (fq.size() < 12) && ($urandom_range(0, 1) == 1);
            wr_data = DATA_WIDTH'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 15) != 0);
            step();
        end
        wr_en = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 100 && (fq.size() != 0 || exp_q.size() != 0); i++) step();
        step();
        dchk("drain_fifo", fq.size(), 0);
        dchk("drain_expected", exp_q.size(), 0);

        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound total run time
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Drives the FIFO read enable and captures the FIFO's registered read data one cycle after each read.
- Re-presents the data as a valid/ready stream with packet framing (m_last every PKT_LEN beats).
- Sits between the FIFO and downstream consumers, so no consumer has to handle FIFO read latency or the empty flag.

Parameters:
- DATA_WIDTH, 16, width of FIFO data and stream data.
- PKT_LEN, 4, beats per packet (>=1); m_last marks beat PKT_LEN.
- CNT_WIDTH, 2, width of the beat counter; must hold PKT_LEN-1 (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  allows new FIFO reads when high.
- fifo_read_en  output  1  read strobe to FIFO read_en.
- fifo_data  input  DATA_WIDTH  FIFO data_out, valid the cycle after an accepted read.
- fifo_empty  input  1  FIFO empty flag.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  last beat of packet.
- flush  input  1  flush request pulse; present only with FIFO_RD_FLUSH_EN.
- flush_busy  output  1  flush in progress; present only with FIFO_RD_FLUSH_EN.

Behaviour:
- Reset (async, reset_n low):
  - fifo_read_en=0, m_valid=0, m_data=0, m_last=0, flush_busy=0.
  - Buffer empty, in-flight flag 0, beat counter 0, state IDLE.
- Internal structure:
  - 3-entry output buffer with occupancy occ (0..3).
  - In-flight flag infl: set the cycle after fifo_read_en=1.
- Read issue:
  - fifo_read_en = (state==RUN) && !fifo_empty && (occ+infl <= 2).
  - Decoded from registered state only; no combinational path from m_ready or m_valid.
  - Steady state gives 1 beat/cycle.
- Data capture:
  - When infl=1, fifo_data is written into the buffer tail that cycle.
  - The buffer never overflows by construction. A write with occ==3 is a design error and is flagged by an assertion.
- Stream output:
  - m_valid = (occ != 0); m_data is the buffer head.
  - A transfer occurs when m_valid && m_ready.
  - m_data/m_valid stay stable while m_valid && !m_ready.
  - Capture and pop in the same cycle leave occ unchanged.
- Framing:
  - m_last = (beat_cnt == PKT_LEN-1) && m_valid.
  - beat_cnt increments on each transfer and wraps to 0 on a transfer with m_last.
  - PKT_LEN=1 gives m_last on every beat.
- FIFO empty contract:
  - fifo_empty is treated as accurate in the cycle it is sampled.
  - With fifo_empty=1, no read is issued.
- State machine:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0.
  - Dropping enable only blocks new reads. An in-flight read still completes into the buffer, and buffered beats still drain to m_*.
  - FLUSH state exists only with the macro (see below).
- Simultaneous events:
  - enable falling in the same cycle as a read issue: that read completes normally.
  - A transfer with m_last and a capture in the same cycle: counter wrap and buffer update both take effect.
- Reset mid-operation: in-flight data and buffered beats are discarded and the counter is cleared. The packet restarts at beat 0 after reset.

Optional Feature:
- Macro name: FIFO_RD_FLUSH_EN.
- Defined:
  - Ports flush and flush_busy exist.
  - flush=1 in any state -> FLUSH next cycle: buffer cleared, m_valid=0, beat_cnt=0, flush_busy=1.
  - In FLUSH: fifo_read_en = !fifo_empty every cycle, and all returned data is discarded.
  - Exit FLUSH when fifo_empty=1 and infl=0. Go to RUN if enable=1, else IDLE; flush_busy drops in the same cycle.
  - flush asserted during FLUSH is ignored.
  - flush has priority over enable.
- Undefined: the ports are absent, the FLUSH state is not built, and the behaviour is as above.

Test Plan:
- Reset with reset_n=0 mid-stream (occ=2, infl=1), release -> all outputs 0; first beat after restart has beat index 0, m_last=0 with PKT_LEN=4.
- FIFO holds 8 words 0x0001..0x0008, enable=1, m_ready=1 -> first m_valid 2 cycles after the first fifo_read_en. 8 consecutive beats, 1/cycle, data in order. m_last on 0x0004 and 0x0008.
- Same 8 words, m_ready toggling 1,0,0,1 -> no data lost or duplicated; occ never exceeds 3; fifo_read_en pauses when occ+infl=3; m_data stable while stalled.
- enable dropped the cycle fifo_read_en=1 with FIFO holding 0x00AA,0x00BB -> 0x00AA delivered, 0x00BB not read; no further fifo_read_en until enable=1.
- FIFO empty, enable=1 for 20 cycles -> fifo_read_en never 1, m_valid=0; then 1 word 0x1234 written -> one read, one beat with m_last=0.
- FIFO_RD_FLUSH_EN: 6 words queued, 2 beats buffered, flush pulse -> m_valid=0 next cycle. FIFO drained by 6 reads, flush_busy high until fifo_empty=1 and infl=0. Next packet starts with beat_cnt=0.
